divider_pipe: RTL
=================

// Module: divider_pipe
// PURPOSE
//  Fully pipelined restoring divider: one N-bit dividend / M-bit divisor per cycle, quotient+remainder
//  after fixed latency. Generalises the constant-dividend reciprocal pipeline to an arbitrary dividend,
//  optional signed mode, divide-by-zero detection, valid/ready flow control and a pass-through tag.
//  Sits between datapath producers (scaling, averaging) and consumers needing exact integer division.
// PARAMETERS
//  N      8  dividend / quotient width (bits), N >= M
//  M      4  divisor / remainder width (bits), M >= 2
//  SIGNED 0  0 = unsigned, 1 = two's-complement operands and results
//  TAG_W  4  sideband tag width carried alongside each operation
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rstn       in   1      asynchronous active-low reset
//  in_valid   in   1      operation offered
//  in_ready   out  1      pipeline accepts this cycle
//  dividend   in   N      numerator
//  divisor    in   M      denominator
//  in_tag     in   TAG_W  sideband, returned unchanged
//  out_valid  out  1      result present
//  out_ready  in   1      consumer takes result this cycle
//  quotient   out  N      result quotient
//  remainder  out  M      result remainder
//  div_zero   out  1      divisor was zero
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (async, rstn=0): every stage valid bit, out_valid, quotient, remainder, div_zero, out_tag -> 0.
//    In-flight operations are discarded; no result emerges for them after rstn rises.
//  - Pipeline = 1 input stage (abs/sign capture, zero detect) + N bit stages + 1 output stage
//    (sign fix-up). LATENCY = N+2 cycles from accept to out_valid with no stalls.
//  - Global advance: adv = out_ready | ~out_valid. in_ready = adv (combinational). When adv=0 every
//    stage holds; when adv=1 every stage shifts one step. Accept = in_valid & in_ready.
//  - Bubbles carry valid=0 and are squeezed only at the output (out_valid=0 lets pipe advance).
//  - out_* stable while out_valid & ~out_ready. Throughput 1/cycle when out_ready held high.
//  - Bit stage k (MSB first): partial remainder R is M+1 bits; R' = {R[M-1:0], a[N-1-k]};
//    if R' >= {1'b0,|d|} then R' -= |d|, q bit = 1 else q bit = 0. Operands travel with the stage.
//  - Unsigned: quotient = dividend / divisor, remainder = dividend % divisor.
//  - Signed: quotient truncates toward zero; remainder takes dividend's sign; |rem| < |divisor|.
//  - Divisor 0: div_zero=1, quotient = all ones, remainder = dividend[M-1:0]; latency unchanged.
//  - Signed overflow (dividend = -2^(N-1), divisor = -1): quotient = dividend, remainder = 0,
//    div_zero=0.
//  - Quotient overflow cannot occur in unsigned mode (quotient width = N).
//  - Simultaneous accept and output take in the same cycle is legal and is the normal steady state.
// STRUCTURE
//  - divider_pkg: function div_latency(N) = N+2; localparams for stage record widths.
//  - Sub-module divider_pipe_stage: one registered restoring step (remainder, remaining dividend bits,
//    partial quotient, |divisor|, sign bits, div_zero, tag, valid), enable = adv, async reset.
//  - Top: input stage, generate loop of N divider_pipe_stage, output fix-up stage, advance logic.
// TESTING (N=8, M=4, TAG_W=4 unless noted)
//  - Unsigned 200/7, tag 3, out_ready=1 -> after 10 cycles quotient=28, remainder=4, tag=3, div_zero=0.
//  - Divisor 0 with dividend 0xA5 -> quotient=0xFF, remainder=0x5, div_zero=1, latency 10.
//  - SIGNED=1: -7/2 -> q=-3 (0xFD), r=-1 (0xF); 7/-2 -> q=-3, r=1; -128/-1 -> q=-128 (0x80), r=0.
//  - Back-to-back 12 ops with out_ready=1 -> 12 results on 12 consecutive cycles, order and tags kept.
//  - Hold out_ready=0 for 5 cycles with pipe full -> in_ready=0, outputs stable, none lost/duplicated.
//  - Assert rstn=0 for 1 cycle with 4 ops in flight -> out_valid=0 immediately, none of the 4 emerge.
//  - Random 10k ops both modes vs reference model, random in_valid/out_ready -> all match, order kept.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared defaults and latency helper for the pipelined divider
package divider_pkg;

  // Default operand geometry used when the divider is instantiated without overrides
  localparam int DIV_N_DEF   = 8;
  localparam int DIV_M_DEF   = 4;
  localparam int DIV_TAG_DEF = 4;

  // Cycles from accept to out_valid: input stage + one stage per quotient bit + output stage
  function automatic int div_latency(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/divider_pipe_stage.sv
// rtl/divider_pipe_stage.sv - one registered restoring-division step
module divider_pipe_stage
  import divider_pkg::*;
#(
  parameter int N     = DIV_N_DEF,
  parameter int M     = DIV_M_DEF,
  parameter int TAG_W = DIV_TAG_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [N-1:0]     aq_i,
  input  logic [M-1:0]     rem_i,
  input  logic [M-1:0]     den_i,
  input  logic             sq_i,
  input  logic             sr_i,
  input  logic             dz_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [N-1:0]     aq_o,
  output logic [M-1:0]     rem_o,
  output logic [M-1:0]     den_o,
  output logic             sq_o,
  output logic             sr_o,
  output logic             dz_o,
  output logic [TAG_W-1:0] tag_o
);

  // aq holds the unconsumed dividend bits in its upper part and the quotient
  // bits produced so far in its lower part; each step shifts one across.
  // The stored remainder is always below |divisor|, so M bits are enough;
  // only the trial value needs the extra bit.
  logic [M:0]       trial;
  logic             fits;
  logic [M-1:0]     rem_d;
  logic [N-1:0]     aq_d;

  logic             valid_q;
  logic [N-1:0]     aq_q;
  logic [M-1:0]     rem_q;
  logic [M-1:0]     den_q;
  logic             sq_q;
  logic             sr_q;
  logic             dz_q;
  logic [TAG_W-1:0] tag_q;

  // Shift in the next dividend bit and subtract the divisor when it fits
  always_comb begin
    trial = {rem_i, aq_i[N-1]};
    fits  = (trial >= {1'b0, den_i});
    rem_d = fits ? M'(trial - {1'b0, den_i}) : trial[M-1:0];
    aq_d  = {aq_i[N-2:0], fits};
  end

  // Advance the whole operation record together with the rest of the pipe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      aq_q    <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
      tag_q   <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      aq_q    <= aq_d;
      rem_q   <= rem_d;
      den_q   <= den_i;
      sq_q    <= sq_i;
      sr_q    <= sr_i;
      dz_q    <= dz_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign aq_o    = aq_q;
  assign rem_o   = rem_q;
  assign den_o   = den_q;
  assign sq_o    = sq_q;
  assign sr_o    = sr_q;
  assign dz_o    = dz_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/divider_pipe.sv
// rtl/divider_pipe.sv - fully pipelined restoring divider with flow control and tag
module divider_pipe
  import divider_pkg::*;
#(
  parameter int N      = DIV_N_DEF,
  parameter int M      = DIV_M_DEF,
  parameter int SIGNED = 0,
  parameter int TAG_W  = DIV_TAG_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dividend,
  input  logic [M-1:0]     divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     quotient,
  output logic [M-1:0]     remainder,
  output logic             div_zero,
  output logic [TAG_W-1:0] out_tag
);

  logic adv;

  logic             neg_a;
  logic             neg_d;
  logic [N-1:0]     abs_a;
  logic [M-1:0]     abs_d;

  // Input stage registers
  logic             s0_valid_q;
  logic [N-1:0]     s0_aq_q;
  logic [M-1:0]     s0_den_q;
  logic             s0_sq_q;
  logic             s0_sr_q;
  logic             s0_dz_q;
  logic [TAG_W-1:0] s0_tag_q;

  // Record entering bit stage k sits at index k; index N is the last bit stage's output
  logic             st_valid [0:N];
  logic [N-1:0]     st_aq    [0:N];
  logic [M-1:0]     st_rem   [0:N];
  logic [M-1:0]     st_den   [0:N];
  logic             st_sq    [0:N];
  logic             st_sr    [0:N];
  logic             st_dz    [0:N];
  logic [TAG_W-1:0] st_tag   [0:N];

  logic [N-1:0]     quotient_d;
  logic [M-1:0]     remainder_d;
  logic             out_valid_q;
  logic [N-1:0]     quotient_q;
  logic [M-1:0]     remainder_q;
  logic             div_zero_q;
  logic [TAG_W-1:0] out_tag_q;

  // The final divisor copy has no consumer once the last bit is resolved
  logic             unused_den;

  // The output register is the only place a bubble can be squeezed, so one
  // shared enable moves every stage at once
  assign adv      = out_ready | ~out_valid_q;
  assign in_ready = adv;

  // Operand magnitudes and signs; -2^(N-1) still fits as an unsigned magnitude
  always_comb begin
    neg_a = (SIGNED != 0) && dividend[N-1];
    neg_d = (SIGNED != 0) && divisor[M-1];
    abs_a = neg_a ? -dividend : dividend;
    abs_d = neg_d ? -divisor : divisor;
  end

  // Input stage: capture magnitudes, result signs and divide-by-zero flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid_q <= 1'b0;
      s0_aq_q    <= '0;
      s0_den_q   <= '0;
      s0_sq_q    <= 1'b0;
      s0_sr_q    <= 1'b0;
      s0_dz_q    <= 1'b0;
      s0_tag_q   <= '0;
    end else if (adv) begin
      s0_valid_q <= in_valid;
      s0_aq_q    <= abs_a;
      s0_den_q   <= abs_d;
      s0_sq_q    <= neg_a ^ neg_d;
      s0_sr_q    <= neg_a;
      s0_dz_q    <= (divisor == '0);
      s0_tag_q   <= in_tag;
    end
  end

  assign st_valid[0] = s0_valid_q;
  assign st_aq[0]    = s0_aq_q;
  assign st_rem[0]   = '0;
  assign st_den[0]   = s0_den_q;
  assign st_sq[0]    = s0_sq_q;
  assign st_sr[0]    = s0_sr_q;
  assign st_dz[0]    = s0_dz_q;
  assign st_tag[0]   = s0_tag_q;

  for (genvar k = 0; k < N; k++) begin : g_bit
    divider_pipe_stage #(.N(N), .M(M), .TAG_W(TAG_W)) u_stage (
      .clk    (clk),
      .rstn   (rstn),
      .adv_i  (adv),
      .valid_i(st_valid[k]),
      .aq_i   (st_aq[k]),
      .rem_i  (st_rem[k]),
      .den_i  (st_den[k]),
      .sq_i   (st_sq[k]),
      .sr_i   (st_sr[k]),
      .dz_i   (st_dz[k]),
      .tag_i  (st_tag[k]),
      .valid_o(st_valid[k+1]),
      .aq_o   (st_aq[k+1]),
      .rem_o  (st_rem[k+1]),
      .den_o  (st_den[k+1]),
      .sq_o   (st_sq[k+1]),
      .sr_o   (st_sr[k+1]),
      .dz_o   (st_dz[k+1]),
      .tag_o  (st_tag[k+1])
    );
  end

  assign unused_den = ^st_den[N];

  // Sign fix-up; with a zero divisor the magnitude remainder is the low
  // dividend bits, so the same negation restores the raw dividend bits
  always_comb begin
    quotient_d  = st_sq[N] ? -st_aq[N] : st_aq[N];
    remainder_d = st_sr[N] ? -st_rem[N] : st_rem[N];
    if (st_dz[N]) begin
      quotient_d = '1;
    end
  end

  // Output stage: holds its result until the consumer takes it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= st_valid[N];
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= st_dz[N];
      out_tag_q   <= st_tag[N];
    end
  end

  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign out_tag   = out_tag_q;

endmodule
